// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg: shared FSM encoding and width helpers for matrix_mult_seq
package matrix_mult_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN} state_e;
  function automatic int sz_w(input int max_size);
    return $clog2(max_size + 1);
  endfunction
  function automatic int acc_w(input int data_w, input int max_size);
    return 2 * data_w + $clog2(max_size);
  endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one unsigned multiply-accumulate lane whose accumulator restarts on the first term
module mac_lane import matrix_mult_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ACC_W = acc_w(DATA_W, 10)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0] acc_q, acc_d;
  always_comb begin
    prod = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
    acc_d = en_i ? (clr_i ? '0 : acc_q) + ACC_W'(prod) : acc_q;
  end
  always_ff @(posedge clk)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc_o = acc_q;
endmodule

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: streamed n x n unsigned matrix multiply, one C row per pass over MAX_SIZE MAC lanes
module matrix_mult_seq import matrix_mult_pkg::*; #(
  parameter int MAX_SIZE = 10,
  parameter int DATA_W = 32,
  parameter int ACC_W = acc_w(DATA_W, MAX_SIZE),
  parameter int SZ_W = sz_w(MAX_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SZ_W-1:0]   matrix_size,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [SZ_W-1:0] MAX_N = SZ_W'(MAX_SIZE);
  localparam logic [SZ_W-1:0] ONE = SZ_W'(1);
  state_e state_q, state_d;
  logic [SZ_W-1:0] n_q, n_d, i_q, i_d, k_q, k_d;
  logic out_valid_q, out_valid_d, done_q, done_d, err_q, err_d;
  logic in_fire, out_fire, last_k, last_i;
  logic [DATA_W-1:0] a_q [MAX_SIZE][MAX_SIZE];
  logic [DATA_W-1:0] b_q [MAX_SIZE][MAX_SIZE];
  logic [ACC_W-1:0] acc [MAX_SIZE];
  // i_q is the row (load row / C row); k_q is the load column, the compute term, then the drain column
  always_comb begin
    in_ready = state_q == LOAD_A || state_q == LOAD_B;
    in_fire = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;
    last_k = k_q == n_q - ONE;
    last_i = i_q == n_q - ONE;
    state_d = state_q;
    n_d = n_q;
    i_d = i_q;
    k_d = k_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (matrix_size != '0 && matrix_size <= MAX_N) begin
          n_d = matrix_size;
          i_d = '0;
          k_d = '0;
          state_d = LOAD_A;
        end else err_d = 1'b1;
      end
      LOAD_A, LOAD_B: if (in_fire) begin
        k_d = last_k ? '0 : k_q + ONE;
        i_d = last_k ? (last_i ? '0 : i_q + ONE) : i_q;
        if (last_k && last_i) state_d = state_q == LOAD_A ? LOAD_B : COMPUTE;
      end
      COMPUTE: begin
        k_d = last_k ? '0 : k_q + ONE;
        if (last_k) state_d = DRAIN;
      end
      DRAIN: if (out_fire) begin
        k_d = last_k ? '0 : k_q + ONE;
        if (last_k) begin
          i_d = last_i ? '0 : i_q + ONE;
          state_d = last_i ? IDLE : COMPUTE;
          done_d = last_i;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = state_d == DRAIN;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      i_q <= '0;
      k_q <= '0;
      out_valid_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      i_q <= i_d;
      k_q <= k_d;
      out_valid_q <= out_valid_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  always_ff @(posedge clk)
    if (in_fire && state_q == LOAD_A) a_q[i_q][k_q] <= in_data;
    else if (in_fire) b_q[i_q][k_q] <= in_data;
  // A[i][k] is broadcast; lanes beyond n see a zero B term so they stay cleared
  for (genvar j = 0; j < MAX_SIZE; j++) begin : g_lane
    mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk(clk),
      .rst(rst),
      .en_i(state_q == COMPUTE),
      .clr_i(k_q == '0),
      .a_i(a_q[i_q][k_q]),
      .b_i(SZ_W'(j) < n_q ? b_q[k_q][j] : '0),
      .acc_o(acc[j])
    );
  end
  assign out_valid = out_valid_q;
  assign out_data = out_valid_q ? acc[k_q] : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb_matrix_mult_seq: randomized scoreboard bench for matrix_mult_seq against a plain-arithmetic model
module tb_matrix_mult_seq;
  localparam int N_MAX = 10;
  localparam int DW = 32;
  localparam int AW = 2 * DW + $clog2(N_MAX);
  localparam int SW = $clog2(N_MAX + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start, in_valid, in_ready, out_valid, out_ready, busy, done, err;
  logic [SW-1:0] matrix_size;
  logic [DW-1:0] in_data;
  logic [AW-1:0] out_data;
  logic s_start, s_in_valid, s_in_ready, s_out_valid, s_busy, s_done, s_err;
  logic s_out_ready = 1'b1;
  logic [SW-1:0] s_size;
  logic [7:0] s_in_data, s_out_data;
  logic [DW-1:0] ma [N_MAX][N_MAX];
  logic [DW-1:0] mb [N_MAX][N_MAX];
  logic [AW-1:0] exp_q [$];
  logic [7:0] exp8_q [$];
  int compared = 0;
  int mismatched = 0;
  int job_cyc = 0;
  int last_job_cyc = 0;
  bit stall_mode = 1'b0;
  bit stalled = 1'b0;
  logic [AW-1:0] held;

  matrix_mult_seq dut (
    .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err(err)
  );

  matrix_mult_seq #(.MAX_SIZE(N_MAX), .DATA_W(8), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .matrix_size(s_size),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .busy(s_busy), .done(s_done), .err(s_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // C[i][j] as a textbook sum of products; callers truncate to the DUT's accumulator width
  function automatic logic [127:0] model(input int n, input int i, input int j);
    logic [127:0] s = '0;
    for (int k = 0; k < n; k++) s += 128'(ma[i][k]) * 128'(mb[k][j]);
    return s;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_s_busy"}, {s_busy, s_in_ready, s_out_valid, s_done, s_err}, 0);
    check({tag, "_s_out_data"}, s_out_data, 0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (stalled && out_valid) check("stall_hold", out_data, held);
    stalled = out_valid && !out_ready;
    held = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_out: got %0h, want no beat", out_data);
      end else check("c_elem", out_data, exp_q.pop_front());
    end
    if (s_out_valid && s_out_ready) begin
      if (exp8_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_out8: got %0h, want no beat", s_out_data);
      end else check("c_elem8", s_out_data, exp8_q.pop_front());
    end
    if (done || err) check("done_err_excl", done && err, 0);
    if (busy) job_cyc++;
    else if (done) begin
      last_job_cyc = job_cyc + 1;
      job_cyc = 0;
    end else job_cyc = 0;
  end

  task automatic push(input bit sm, input logic [DW-1:0] d, input bit gaps);
    bit ok;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    if (sm) begin
      s_in_valid = 1'b1;
      s_in_data = d[7:0];
    end else begin
      in_valid = 1'b1;
      in_data = d;
    end
    for (int t = 0; ; t++) begin
      ok = sm ? s_in_ready : in_ready;
      @(negedge clk);
      if (ok) break;
      if (t == 50) begin
        compared++;
        mismatched++;
        $display("FAIL in_ready_timeout: got in_ready=0 for 50 cycles, want 1");
        break;
      end
    end
    in_valid = 1'b0;
    s_in_valid = 1'b0;
  endtask

  task automatic run_job(input bit sm, input int n, input bit gaps, input bit stalls);
    int t;
    stall_mode = stalls;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if (sm) exp8_q.push_back(8'(model(n, i, j)));
        else exp_q.push_back(AW'(model(n, i, j)));
    if (sm) begin
      s_start = 1'b1;
      s_size = SW'(n);
    end else begin
      start = 1'b1;
      matrix_size = SW'(n);
    end
    @(negedge clk);
    start = 1'b0;
    s_start = 1'b0;
    for (int i = 0; i < n; i++) for (int j = 0; j < n; j++) push(sm, ma[i][j], gaps);
    for (int i = 0; i < n; i++) for (int j = 0; j < n; j++) push(sm, mb[i][j], gaps);
    for (t = 0; t < 5000; t++) begin
      if (sm ? s_done : done) break;
      @(negedge clk);
    end
    if (t == 5000) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done in 5000 cycles, want done (n=%0d)", n);
    end else check("busy_at_done", sm ? s_busy : busy, 0);
    stall_mode = 1'b0;
    @(negedge clk);
    check("done_one_cycle", sm ? s_done : done, 0);
    check("busy_after_done", sm ? s_busy : busy, 0);
    check("queue_drained", sm ? exp8_q.size() : exp_q.size(), 0);
  endtask

  task automatic set_spec_mats();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
  endtask

  task automatic randomize_mats(input logic [DW-1:0] mask);
    for (int i = 0; i < N_MAX; i++)
      for (int j = 0; j < N_MAX; j++) begin
        ma[i][j] = $urandom & mask;
        mb[i][j] = $urandom & mask;
      end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish by 900us, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; matrix_size = '0; in_valid = 1'b0; in_data = '0;
    s_start = 1'b0; s_size = '0; s_in_valid = 1'b0; s_in_data = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    set_spec_mats();
    run_job(0, 2, 0, 0);
    check("cycles_n2", last_job_cyc, 17);
    ma[0][0] = 7;
    mb[0][0] = 6;
    run_job(0, 1, 0, 0);
    check("cycles_n1", last_job_cyc, 5);
    randomize_mats('1);
    for (int i = 0; i < N_MAX; i++) for (int j = 0; j < N_MAX; j++) ma[i][j] = (i == j) ? 1 : 0;
    run_job(0, N_MAX, 0, 0);
    randomize_mats('1);
    run_job(0, 3, 1, 1);
    for (int r = 0; r < 3; r++) begin
      randomize_mats('1);
      run_job(0, $urandom_range(1, N_MAX), 1, 1);
    end
    foreach (matrix_size[b]) begin end
    for (int s = 0; s < 2; s++) begin
      start = 1'b1;
      matrix_size = (s == 0) ? SW'(0) : SW'(N_MAX + 1);
      @(negedge clk);
      start = 1'b0;
      check("err_pulse", err, 1);
      check("err_busy", busy, 0);
      check("err_in_ready", in_ready, 0);
      @(negedge clk);
      check("err_cleared", err, 0);
      check("err_busy_after", busy, 0);
    end
    randomize_mats('1);
    start = 1'b1;
    matrix_size = SW'(2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) push(0, ma[i / 2][i % 2], 0);
    for (int i = 0; i < 2; i++) push(0, mb[0][i], 0);
    check("mid_load_b_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid");
    rst = 1'b0;
    set_spec_mats();
    run_job(0, 2, 0, 0);
    check("cycles_after_rst", last_job_cyc, 17);
    ma[0][0] = 255;
    mb[0][0] = 255;
    run_job(1, 1, 0, 0);
    randomize_mats(32'hff);
    run_job(1, 3, 1, 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
